// File: rtl/br_perf_monitor.sv
// Branch-prediction performance monitor: counts RUN cycles, branches and mispredictions,
// and closes fixed-size branch windows into snapshots drained over a valid/ready port.
module br_perf_monitor #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned WINDOW    = 1024,
    parameter logic [31:0] HALT_INSN = 32'h0010_0073
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             br_instr_i,
    input  logic             br_misses_i,
    input  logic [31:0]      instr_i,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] cyc_cnt_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic             snap_valid_o,
    input  logic             snap_ready_i,
    output logic [CNT_W-1:0] snap_br_o,
    output logic [CNT_W-1:0] snap_miss_o,
    output logic [15:0]      snap_idx_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StHalt  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, br_q, br_d, miss_q, miss_d;
    logic [CNT_W-1:0] win_br_q, win_br_d, win_miss_q, win_miss_d;
    logic [CNT_W-1:0] snap_br_q, snap_br_d, snap_miss_q, snap_miss_d;
    logic [15:0]      win_idx_q, win_idx_d, snap_idx_q, snap_idx_d;
    logic             snap_valid_q, snap_valid_d, overrun_q, overrun_d;

    logic             run, halt_det, full_close, close;
    logic [CNT_W-1:0] win_br_inc, win_miss_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        br_d         = br_q;
        miss_d       = miss_q;
        win_br_d     = win_br_q;
        win_miss_d   = win_miss_q;
        win_idx_d    = win_idx_q;
        snap_br_d    = snap_br_q;
        snap_miss_d  = snap_miss_q;
        snap_idx_d   = snap_idx_q;
        snap_valid_d = snap_valid_q;
        overrun_d    = overrun_q;

        run      = (state_q == StRun);
        halt_det = run && (instr_i == HALT_INSN);

        unique case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun: begin
                if (halt_det)   state_d = StHalt;
                else if (!en_i) state_d = StPause;
            end
            StPause: if (en_i) state_d = StRun;
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase

        // win_br never exceeds WINDOW-1, so the plain add cannot wrap.
        win_br_inc   = win_br_q + CNT_W'(br_instr_i);
        win_miss_inc = sat_inc(win_miss_q, br_misses_i);
        full_close   = run && br_instr_i && (win_br_q == WinLast);
        close        = full_close ||
                       (halt_det && ((win_br_inc != '0) || (win_miss_inc != '0)));

        if (run) begin
            cyc_d      = sat_inc(cyc_q, 1'b1);
            br_d       = sat_inc(br_q, br_instr_i);
            miss_d     = sat_inc(miss_q, br_misses_i);
            win_br_d   = win_br_inc;
            win_miss_d = win_miss_inc;
        end

        if (close) begin
            win_br_d   = '0;
            win_miss_d = '0;
            win_idx_d  = win_idx_q + 16'd1;
            if (!snap_valid_q || snap_ready_i) begin
                snap_br_d    = win_br_inc;
                snap_miss_d  = win_miss_inc;
                snap_idx_d   = win_idx_q;
                snap_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (snap_valid_q && snap_ready_i) begin
            snap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q      <= StIdle;
            cyc_q        <= '0;
            br_q         <= '0;
            miss_q       <= '0;
            win_br_q     <= '0;
            win_miss_q   <= '0;
            win_idx_q    <= '0;
            snap_br_q    <= '0;
            snap_miss_q  <= '0;
            snap_idx_q   <= '0;
            snap_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            br_q         <= br_d;
            miss_q       <= miss_d;
            win_br_q     <= win_br_d;
            win_miss_q   <= win_miss_d;
            win_idx_q    <= win_idx_d;
            snap_br_q    <= snap_br_d;
            snap_miss_q  <= snap_miss_d;
            snap_idx_q   <= snap_idx_d;
            snap_valid_q <= snap_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign state_o      = state_q;
    assign halted_o     = (state_q == StHalt);
    assign cyc_cnt_o    = cyc_q;
    assign br_cnt_o     = br_q;
    assign miss_cnt_o   = miss_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_br_o    = snap_br_q;
    assign snap_miss_o  = snap_miss_q;
    assign snap_idx_o   = snap_idx_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_br_perf_monitor.sv
// Scoreboard bench for br_perf_monitor: a WINDOW=4 instance checked through its snapshot
// port, plus a CNT_W=4 instance sharing the inputs for saturation.
module tb_br_perf_monitor;

    localparam logic [31:0] HALT = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst, en, clr, br, miss, ready;
    logic [31:0] instr;

    logic [1:0]  state;
    logic        halted, snap_valid, overrun;
    logic [31:0] cyc_cnt, br_cnt, miss_cnt, snap_br, snap_miss;
    logic [15:0] snap_idx;

    logic [1:0]  s_state;
    logic        s_halted, s_snap_valid, s_overrun;
    logic [3:0]  s_cyc, s_br, s_miss, s_snap_br, s_snap_miss;
    logic [15:0] s_snap_idx;

    typedef struct {
        logic [31:0] br;
        logic [31:0] miss;
        logic [15:0] idx;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    br_perf_monitor #(.CNT_W(32), .WINDOW(4), .HALT_INSN(HALT)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .br_instr_i(br),
        .br_misses_i(miss), .instr_i(instr), .state_o(state), .halted_o(halted),
        .cyc_cnt_o(cyc_cnt), .br_cnt_o(br_cnt), .miss_cnt_o(miss_cnt),
        .snap_valid_o(snap_valid), .snap_ready_i(ready), .snap_br_o(snap_br),
        .snap_miss_o(snap_miss), .snap_idx_o(snap_idx), .overrun_o(overrun)
    );

    br_perf_monitor #(.CNT_W(4), .WINDOW(4), .HALT_INSN(HALT)) dut_sat (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .br_instr_i(br),
        .br_misses_i(miss), .instr_i(instr), .state_o(s_state), .halted_o(s_halted),
        .cyc_cnt_o(s_cyc), .br_cnt_o(s_br), .miss_cnt_o(s_miss),
        .snap_valid_o(s_snap_valid), .snap_ready_i(ready), .snap_br_o(s_snap_br),
        .snap_miss_o(s_snap_miss), .snap_idx_o(s_snap_idx), .overrun_o(s_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] b, input logic [31:0] m, input logic [15:0] i);
        snap_t s;
        s.br   = b;
        s.miss = m;
        s.idx  = i;
        exp_q.push_back(s);
    endtask

    task automatic tick(input logic e, input logic b, input logic m, input logic [31:0] ins);
        en    = e;
        br    = b;
        miss  = m;
        instr = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick(en, 1'b0, 1'b0, 32'h0);
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: an accepted snapshot is popped and compared at the negedge before the handshake.
    always @(negedge clk) begin
        if (!rst && snap_valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL snap_unexpected: got idx %0d br %0d, want none", snap_idx, snap_br);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                chk("snap_br", snap_br, e.br);
                chk("snap_miss", snap_miss, e.miss);
                chk("snap_idx", 32'(snap_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; en = 1'b0; br = 1'b0; miss = 1'b0; ready = 1'b0;
        instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_br", br_cnt, 32'd0);
        chk("rst_miss", miss_cnt, 32'd0);
        chk("rst_valid", 32'(snap_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Basic counting: one cycle to enter RUN, then 10 counted cycles.
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, (k == 1 || k == 4 || k == 7), (k == 4), 32'h0);
        end
        chk("t1_cyc", cyc_cnt, 32'd10);
        chk("t1_br", br_cnt, 32'd3);
        chk("t1_miss", miss_cnt, 32'd1);
        chk("t1_state", 32'(state), 32'd1);
        chk("t1_valid", 32'(snap_valid), 32'd0);

        // Two full windows drained immediately; the 4th branch's miss belongs to window 0.
        do_clr();
        ready = 1'b1;
        push(32'd4, 32'd1, 16'd0);
        push(32'd4, 32'd0, 16'd1);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b1, (k == 3), 32'h0);
        end
        drain();
        chk("t2_overrun", 32'(overrun), 32'd0);

        // Reader stalled: idx0 held, idx1/idx2 dropped, next close is idx3.
        do_clr();
        ready = 1'b0;
        push(32'd4, 32'd0, 16'd0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_valid_held", 32'(snap_valid), 32'd1);
        chk("t3_idx_held", 32'(snap_idx), 32'd0);
        ready = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        chk("t3_valid_drop", 32'(snap_valid), 32'd0);
        push(32'd4, 32'd0, 16'd3);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
        end
        drain();
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);

        // Halt with a branch in the same cycle flushes a partial window of 3.
        do_clr();
        push(32'd4, 32'd0, 16'd0);
        push(32'd3, 32'd0, 16'd1);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("t4_halted_before", 32'(halted), 32'd0);
        tick(1'b1, 1'b1, 1'b0, HALT);
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_state", 32'(state), 32'd3);
        chk("t4_br", br_cnt, 32'd7);
        chk("t4_cyc", cyc_cnt, 32'd7);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1, 1'b1, 32'h0);
        end
        chk("t4_br_frozen", br_cnt, 32'd7);
        chk("t4_miss_frozen", miss_cnt, 32'd0);
        chk("t4_cyc_frozen", cyc_cnt, 32'd7);
        chk("t4_still_halted", 32'(state), 32'd3);
        drain();

        // en toggling every 3 cycles from IDLE; halt words in PAUSE are ignored.
        do_clr();
        for (int k = 0; k < 12; k++) begin
            tick(((k / 3) % 2) == 0, 1'b0, 1'b0, (k == 4 || k == 10) ? HALT : 32'h0);
            chk($sformatf("t5_state_%0d", k), 32'(state), (((k / 3) % 2) == 0) ? 32'd1 : 32'd2);
        end
        chk("t5_cyc", cyc_cnt, 32'd6);
        chk("t5_halted", 32'(halted), 32'd0);

        // Saturation on the 4-bit instance; the wide instance sees 5 full windows.
        do_clr();
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(32'd4, 32'd0, 16'(k));
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
        end
        chk("t6_sat_br", 32'(s_br), 32'd15);
        chk("t6_sat_cyc", 32'(s_cyc), 32'd15);
        chk("t6_wide_br", br_cnt, 32'd20);
        clr = 1'b1;
        tick(1'b1, 1'b1, 1'b1, 32'h0);
        clr = 1'b0;
        chk("t6_clr_state", 32'(s_state), 32'd0);
        chk("t6_clr_br", 32'(s_br), 32'd0);
        chk("t6_clr_cyc", 32'(s_cyc), 32'd0);
        chk("t6_clr_miss", 32'(s_miss), 32'd0);
        chk("t6_clr_valid", 32'(s_snap_valid), 32'd0);
        chk("t6_clr_overrun", 32'(s_overrun), 32'd0);
        chk("t6_clr_idx", 32'(s_snap_idx), 32'd0);
        chk("t6_clr_wide_state", 32'(state), 32'd0);
        chk("t6_clr_wide_br", br_cnt, 32'd0);
        chk("t6_clr_wide_valid", 32'(snap_valid), 32'd0);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
